// File: rtl/byte_lane_dly_pkg.sv
// Shared constants and FSM state type for the byte-lane delay loader.
// Address map matches the lane's dly_addr decoding.
package byte_lane_dly_pkg;

    localparam logic [4:0] DQ_BASE = 5'd0;
    localparam logic [4:0] DQS_OUT = 5'd8;
    localparam logic [4:0] DM_OUT  = 5'd9;
    localparam logic [4:0] IN_BASE = 5'd16;
    localparam logic [4:0] DQS_IN  = 5'd24;

    localparam int OUT_CNT = 10;
    localparam int IN_CNT  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_GAP,
        S_SETTLE,
        S_SET,
        S_DONE
    } state_e;

    function automatic logic is_out(input logic [4:0] a);
        return int'(a) < int'(DQ_BASE) + OUT_CNT;
    endfunction

    function automatic logic is_in(input logic [4:0] a);
        return (int'(a) >= int'(IN_BASE)) && (int'(a) < int'(IN_BASE) + IN_CNT);
    endfunction

endpackage

// File: rtl/byte_lane_dly_loader_if.sv
// Host/table side and lane side signals of the delay loader.
// master drives the host inputs; slave is the loader itself.
interface byte_lane_dly_loader_if;

    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       sel_out;
    logic       sel_in;
    logic       busy;
    logic       done;
    logic [7:0] dly_data;
    logic [4:0] dly_addr;
    logic       ld_delay;
    logic       set;

    modport master (
        output wr_en, wr_addr, wr_data, start, sel_out, sel_in,
        input  busy, done, dly_data, dly_addr, ld_delay, set
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, sel_out, sel_in,
        output busy, done, dly_data, dly_addr, ld_delay, set
    );

endinterface

// File: rtl/byte_lane_dly_addr_seq.sv
// Combinational next-address search over the implemented delay addresses.
// Ascending scan, so the output group naturally precedes the input group.
module byte_lane_dly_addr_seq
    import byte_lane_dly_pkg::*;
(
    input  logic [4:0]  cur_addr,
    input  logic        from_start,
    input  logic        sel_out,
    input  logic        sel_in,
    input  logic [31:0] mask,
    output logic [4:0]  nxt_addr,
    output logic        last
);

    logic [31:0] en;
    logic        found;

    always_comb begin
        en       = '0;
        found    = 1'b0;
        nxt_addr = '0;
        for (int i = 0; i < 32; i++) begin
            en[i] = mask[i] & ((sel_out & is_out(5'(i))) | (sel_in & is_in(5'(i))));
        end
        for (int i = 31; i >= 0; i--) begin
            if (en[i] && (from_start || i > int'(cur_addr))) begin
                found    = 1'b1;
                nxt_addr = 5'(i);
            end
        end
        last = ~found;
    end

endmodule

// File: rtl/byte_lane_dly_loader.sv
// Walks the local 32x8 delay table into one byte lane (ld_delay per address, then set).
// Define BYTE_LANE_DLY_DIRTY_EN to load only entries written since their last load.
module byte_lane_dly_loader
    import byte_lane_dly_pkg::*;
#(
    parameter int LD_GAP        = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk_div,
    input  logic                  rst,
    byte_lane_dly_loader_if.slave bus
);

    localparam logic [3:0] GAP_N    = (LD_GAP > 0) ? 4'(LD_GAP - 1) : 4'd0;
    localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES - 1);

    logic [7:0] mem [32];

    state_e     state_q, state_d;
    logic [4:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sel_out_q, sel_out_d;
    logic       sel_in_q, sel_in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       set_q, set_d;
    logic       ld_q, ld_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic [31:0] mask;
    logic [4:0]  seq_nxt;
    logic        seq_last;
    logic        seq_first;

`ifdef BYTE_LANE_DLY_DIRTY_EN
    logic [31:0] dirty_q, dirty_d;

    // A write landing on the fetch cycle wins, so the new value is loaded next run
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == S_FETCH) dirty_d[ptr_q] = 1'b0;
        if (bus.wr_en) dirty_d[bus.wr_addr] = 1'b1;
    end

    always_ff @(posedge clk_div) begin
        if (rst) dirty_q <= '1;
        else     dirty_q <= dirty_d;
    end

    assign mask = dirty_q;
`else
    assign mask = '1;
`endif

    always_ff @(posedge clk_div) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    assign seq_first = (state_q == S_IDLE);

    byte_lane_dly_addr_seq u_seq (
        .cur_addr   (ptr_q),
        .from_start (seq_first),
        .sel_out    (seq_first ? bus.sel_out : sel_out_q),
        .sel_in     (seq_first ? bus.sel_in : sel_in_q),
        .mask       (mask),
        .nxt_addr   (seq_nxt),
        .last       (seq_last)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_out_d = sel_out_q;
        sel_in_d  = sel_in_q;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_out_d = bus.sel_out;
                    sel_in_d  = bus.sel_in;
                    if (seq_last) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_N;
                    end else begin
                        ptr_d   = seq_nxt;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                addr_d  = ptr_q;
                data_d  = mem[ptr_q];
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (seq_last) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_N;
                end else begin
                    ptr_d   = seq_nxt;
                    cnt_d   = GAP_N;
                    state_d = (LD_GAP > 0) ? S_GAP : S_FETCH;
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) state_d = S_FETCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) state_d = S_SET;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_SET:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered decodes of the state being entered
    always_comb begin
        ld_d   = (state_d == S_LOAD);
        set_d  = (state_d == S_SET);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel_out_q <= 1'b0;
            sel_in_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            set_q     <= 1'b0;
            ld_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_out_q <= sel_out_d;
            sel_in_q  <= sel_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            set_q     <= set_d;
            ld_q      <= ld_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.set      = set_q;
    assign bus.ld_delay = ld_q;
    assign bus.dly_addr = addr_q;
    assign bus.dly_data = data_q;

endmodule

// File: tb/tb_byte_lane_dly_loader.sv
// Directed bench for byte_lane_dly_loader: LD_GAP=0 and LD_GAP=3 instances.
// Times are cycles after the cycle in which start was sampled.
module tb_byte_lane_dly_loader;

    logic clk_div = 1'b0;
    logic rst = 1'b1;
    always #5 clk_div = ~clk_div;

    byte_lane_dly_loader_if b0();
    byte_lane_dly_loader_if b3();

    byte_lane_dly_loader #(.LD_GAP(0), .SETTLE_CYCLES(2)) u0 (
        .clk_div (clk_div),
        .rst     (rst),
        .bus     (b0)
    );

    byte_lane_dly_loader #(.LD_GAP(3), .SETTLE_CYCLES(2)) u3 (
        .clk_div (clk_div),
        .rst     (rst),
        .bus     (b3)
    );

    int checks = 0;
    int errors = 0;

    bit sel_dut = 1'b0;
    wire       s_ld   = sel_dut ? b3.ld_delay : b0.ld_delay;
    wire       s_set  = sel_dut ? b3.set : b0.set;
    wire       s_done = sel_dut ? b3.done : b0.done;
    wire       s_busy = sel_dut ? b3.busy : b0.busy;
    wire [4:0] s_addr = sel_dut ? b3.dly_addr : b0.dly_addr;
    wire [7:0] s_data = sel_dut ? b3.dly_data : b0.dly_data;

    int ld_t[$];
    int ld_a[$];
    int ld_d[$];
    int set_t[$];
    int done_t[$];
    logic [16:0] snap [0:255];
    int ws_k[$];
    int ws_a[$];
    int ws_d[$];

    function automatic int exp_addr(input int i);
        return (i < 10) ? i : i + 6;
    endfunction

    function automatic int exp_data(input int a);
        return (a < 16) ? 'h10 + a : 'h40 + a - 16;
    endfunction

    function automatic int find_data(input int a);
        foreach (ld_a[j]) if (ld_a[j] == a) return ld_d[j];
        return -1;
    endfunction

    task automatic rst_pulse();
        @(posedge clk_div); #1 rst = 1'b1;
        @(posedge clk_div); #1 rst = 1'b0;
    endtask

    task automatic write_one(input int a, input int d);
        @(posedge clk_div); #1;
        b0.wr_en = 1'b1; b0.wr_addr = 5'(a); b0.wr_data = 8'(d);
        @(posedge clk_div); #1;
        b0.wr_en = 1'b0;
    endtask

    // Pulses start, records n cycles; rk1/rk2 re-pulse start, rst_k pulses rst
    task automatic capture(input bit which, input int n, input int rk1,
                           input int rk2, input int rst_k);
        sel_dut = which;
        ld_t.delete(); ld_a.delete(); ld_d.delete();
        set_t.delete(); done_t.delete();
        @(posedge clk_div); #1;
        if (which) b3.start = 1'b1; else b0.start = 1'b1;
        @(posedge clk_div); #1;
        b0.start = 1'b0; b3.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_div);
            snap[k] = {s_busy, s_done, s_ld, s_set, s_addr, s_data};
            if (s_ld) begin
                ld_t.push_back(k); ld_a.push_back(int'(s_addr)); ld_d.push_back(int'(s_data));
            end
            if (s_set) set_t.push_back(k);
            if (s_done) done_t.push_back(k);
            @(posedge clk_div); #1;
            b0.start = !which && (k + 1 == rk1 || k + 1 == rk2);
            b3.start = which && (k + 1 == rk1 || k + 1 == rk2);
            rst = (k + 1 == rst_k);
            b0.wr_en = 1'b0;
            foreach (ws_k[j]) begin
                if (ws_k[j] == k + 1) begin
                    b0.wr_en = 1'b1; b0.wr_addr = 5'(ws_a[j]); b0.wr_data = 8'(ws_d[j]);
                end
            end
        end
        b0.start = 1'b0; b3.start = 1'b0; b0.wr_en = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_div);
        @(negedge clk_div);
        checks++;
        if ({b0.busy, b0.done, b0.ld_delay, b0.set, b0.dly_addr, b0.dly_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_u0 got %h want 0",
                     {b0.busy, b0.done, b0.ld_delay, b0.set, b0.dly_addr, b0.dly_data});
        end
        checks++;
        if ({b3.busy, b3.done, b3.ld_delay, b3.set, b3.dly_addr, b3.dly_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_u3 got %h want 0",
                     {b3.busy, b3.done, b3.ld_delay, b3.set, b3.dly_addr, b3.dly_data});
        end
        @(posedge clk_div); #1 rst = 1'b0;
    endtask

    task automatic load_table();
        for (int a = 0; a < 32; a++) begin
            if (a < 10 || (a >= 16 && a < 25) || a == 12) begin
                @(posedge clk_div); #1;
                b0.wr_en = 1'b1; b0.wr_addr = 5'(a);
                b0.wr_data = (a == 12) ? 8'hFF : 8'(exp_data(a));
                b3.wr_en = b0.wr_en; b3.wr_addr = b0.wr_addr; b3.wr_data = b0.wr_data;
            end
        end
        @(posedge clk_div); #1;
        b0.wr_en = 1'b0; b3.wr_en = 1'b0;
    endtask

    task automatic test_full_run();
        b0.sel_out = 1'b1; b0.sel_in = 1'b1;
        capture(1'b0, 60, 5, 42, 0);
        checks++;
        if (ld_t.size() != 19) begin
            errors++; $display("FAIL full_count got %0d want 19", ld_t.size());
        end
        for (int i = 0; i < ld_t.size() && i < 19; i++) begin
            checks++;
            if (ld_t[i] != 2 + 2 * i || ld_a[i] != exp_addr(i) || ld_d[i] != exp_data(exp_addr(i))) begin
                errors++;
                $display("FAIL full_ld%0d got t%0d a%0d d%h want t%0d a%0d d%h", i,
                         ld_t[i], ld_a[i], ld_d[i], 2 + 2 * i, exp_addr(i), exp_data(exp_addr(i)));
            end
        end
        checks++;
        if (set_t.size() != 1 || set_t[0] != 41) begin
            errors++; $display("FAIL full_set got n%0d want one at 41", set_t.size());
        end
        checks++;
        if (done_t.size() != 1 || done_t[0] != 42) begin
            errors++; $display("FAIL full_done got n%0d want one at 42", done_t.size());
        end
        for (int k = 1; k <= 60; k++) begin
            checks++;
            if (snap[k][16] !== (k <= 41)) begin
                errors++; $display("FAIL full_busy t%0d got %b want %b", k, snap[k][16], k <= 41);
            end
        end
        checks++;
        if (snap[50][12:0] !== {5'd24, 8'h48}) begin
            errors++; $display("FAIL full_hold got %h want %h", snap[50][12:0], {5'd24, 8'h48});
        end
    endtask

    task automatic test_no_select();
        b0.sel_out = 1'b0; b0.sel_in = 1'b0;
        capture(1'b0, 10, 0, 0, 0);
        checks++;
        if (ld_t.size() != 0) begin
            errors++; $display("FAIL nosel_count got %0d want 0", ld_t.size());
        end
        checks++;
        if (set_t.size() != 1 || set_t[0] != 3) begin
            errors++; $display("FAIL nosel_set got n%0d want one at 3", set_t.size());
        end
        checks++;
        if (done_t.size() != 1 || done_t[0] != 4) begin
            errors++; $display("FAIL nosel_done got n%0d want one at 4", done_t.size());
        end
    endtask

    task automatic test_ld_gap();
        b3.sel_out = 1'b1; b3.sel_in = 1'b0;
        capture(1'b1, 60, 0, 0, 0);
        checks++;
        if (ld_t.size() != 10) begin
            errors++; $display("FAIL gap_count got %0d want 10", ld_t.size());
        end
        for (int i = 0; i < ld_t.size() && i < 10; i++) begin
            checks++;
            if (ld_t[i] != 2 + 5 * i || ld_a[i] != i || ld_d[i] != 'h10 + i) begin
                errors++;
                $display("FAIL gap_ld%0d got t%0d a%0d d%h want t%0d a%0d d%h", i,
                         ld_t[i], ld_a[i], ld_d[i], 2 + 5 * i, i, 'h10 + i);
            end
        end
        checks++;
        if (set_t.size() != 1 || set_t[0] != 50) begin
            errors++; $display("FAIL gap_set got n%0d want one at 50", set_t.size());
        end
        checks++;
        if (done_t.size() != 1 || done_t[0] != 51) begin
            errors++; $display("FAIL gap_done got n%0d want one at 51", done_t.size());
        end
    endtask

    task automatic test_abort();
        rst_pulse();
        b0.sel_out = 1'b1; b0.sel_in = 1'b1;
        capture(1'b0, 40, 5, 0, 12);
        checks++;
        if (ld_t.size() != 6 || ld_t[5] != 12) begin
            errors++; $display("FAIL abort_count got %0d want 6 ending at 12", ld_t.size());
        end
        checks++;
        if (snap[13] !== 17'd0) begin
            errors++; $display("FAIL abort_outs got %h want 0", snap[13]);
        end
        checks++;
        if (set_t.size() != 0 || done_t.size() != 0) begin
            errors++; $display("FAIL abort_set got set%0d done%0d want 0 0", set_t.size(), done_t.size());
        end
        for (int k = 13; k <= 40; k++) begin
            checks++;
            if (snap[k][16] !== 1'b0) begin
                errors++; $display("FAIL abort_idle t%0d got busy %b want 0", k, snap[k][16]);
            end
        end
        capture(1'b0, 45, 0, 0, 0);
        checks++;
        if (ld_t.size() != 19 || set_t.size() != 1 || set_t[0] != 41) begin
            errors++; $display("FAIL abort_rerun got n%0d set%0d want 19 1", ld_t.size(), set_t.size());
        end
        checks++;
        if (find_data(24) != 'h48) begin
            errors++; $display("FAIL abort_table got %h want 48", find_data(24));
        end
    endtask

    task automatic test_mid_write();
        rst_pulse();
        b0.sel_out = 1'b1; b0.sel_in = 1'b1;
        ws_k = '{10, 11, 12};
        ws_a = '{20, 5, 3};
        ws_d = '{'hAB, 'hEE, 'hCD};
        capture(1'b0, 45, 0, 0, 0);
        ws_k.delete(); ws_a.delete(); ws_d.delete();
        checks++;
        if (find_data(20) != 'hAB) begin
            errors++; $display("FAIL mid_a20 got %h want ab", find_data(20));
        end
        checks++;
        if (find_data(5) != 'h15) begin
            errors++; $display("FAIL mid_a5_rbw got %h want 15", find_data(5));
        end
        checks++;
        if (find_data(3) != 'h13) begin
            errors++; $display("FAIL mid_a3 got %h want 13", find_data(3));
        end
        capture(1'b0, 45, 0, 0, 0);
        checks++;
        if (find_data(3) != 'hCD) begin
            errors++; $display("FAIL next_a3 got %h want cd", find_data(3));
        end
        checks++;
        if (find_data(5) != 'hEE) begin
            errors++; $display("FAIL next_a5 got %h want ee", find_data(5));
        end
`ifndef BYTE_LANE_DLY_DIRTY_EN
        checks++;
        if (ld_t.size() != 19 || find_data(20) != 'hAB) begin
            errors++; $display("FAIL next_full got n%0d a20 %h want 19 ab", ld_t.size(), find_data(20));
        end
`endif
    endtask

`ifdef BYTE_LANE_DLY_DIRTY_EN
    task automatic test_dirty();
        rst_pulse();
        b0.sel_out = 1'b1; b0.sel_in = 1'b1;
        capture(1'b0, 45, 0, 0, 0);
        checks++;
        if (ld_t.size() != 19) begin
            errors++; $display("FAIL dirty_first got %0d want 19", ld_t.size());
        end
        write_one(5, 'h55);
        write_one(22, 'h66);
        capture(1'b0, 20, 0, 0, 0);
        checks++;
        if (ld_t.size() != 2) begin
            errors++; $display("FAIL dirty_count got %0d want 2", ld_t.size());
        end else begin
            checks++;
            if (ld_t[0] != 2 || ld_a[0] != 5 || ld_d[0] != 'h55 ||
                ld_t[1] != 4 || ld_a[1] != 22 || ld_d[1] != 'h66) begin
                errors++;
                $display("FAIL dirty_lds got t%0d a%0d d%h t%0d a%0d d%h want t2 a5 d55 t4 a22 d66",
                         ld_t[0], ld_a[0], ld_d[0], ld_t[1], ld_a[1], ld_d[1]);
            end
        end
        checks++;
        if (set_t.size() != 1 || set_t[0] != 7) begin
            errors++; $display("FAIL dirty_set got n%0d want one at 7", set_t.size());
        end
    endtask
`endif

    initial begin
        b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0;
        b0.start = 1'b0; b0.sel_out = 1'b0; b0.sel_in = 1'b0;
        b3.wr_en = 1'b0; b3.wr_addr = '0; b3.wr_data = '0;
        b3.start = 1'b0; b3.sel_out = 1'b0; b3.sel_in = 1'b0;
        test_reset();
        load_table();
        test_full_run();
        test_no_select();
        test_ld_gap();
        test_abort();
        test_mid_write();
`ifdef BYTE_LANE_DLY_DIRTY_EN
        test_dirty();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_lane_dly_loader.md
Name: byte_lane_dly_loader

Overview:
Sequencer that drives the byte-lane delay-programming interface (dly_data, dly_addr, ld_delay, set) from a locally held 32x8 delay table.
- Host software writes delay values into the table at any time.
- On start, the block walks every implemented delay address, emitting one ld_delay strobe per address, then a single set strobe.
- Sits between the controller register space and one byte lane; all activity is in the clk_div domain.

Parameters:
LD_GAP, 0, idle cycles inserted between consecutive ld_delay strobes (0..15).
SETTLE_CYCLES, 2, idle cycles between the last ld_delay and the set strobe (1..15).

Ports:
clk_div  input  1  single clock; all logic is synchronous to its rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  table write strobe.
wr_addr  input  5  table entry; address map is identical to the lane's dly_addr.
wr_data  input  8  delay value; 3 LSBs are the fine delay.
start  input  1  single-cycle request to load delays; ignored while busy.
sel_out  input  1  include output delays (addresses 0-9); sampled with start.
sel_in  input  1  include input delays (addresses 16-24); sampled with start.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse when the sequence completes.
dly_data  output  8  delay value presented to the lane.
dly_addr  output  5  delay address presented to the lane.
ld_delay  output  1  per-address load strobe.
set  output  1  apply-all strobe.

Behaviour:
- Reset: busy, done, ld_delay, set = 0; dly_addr = 0; dly_data = 0. All outputs are registered.
- Reset does not clear the table, because it is RAM-based. Table power-up value is 0.
- Address list:
  - Output group, in order: 0-7 (DQ odelay), 8 (DQS odelay), 9 (DM odelay).
  - Input group, in order: 16-23 (DQ idelay), 24 (DQS idelay).
  - The output group always precedes the input group. All other addresses are never emitted.
- Table writes:
  - Accepted every cycle, including while busy.
  - Writes to unimplemented addresses are stored but never emitted.
  - A write to an entry in the same cycle that entry is read returns the old value (read-before-write).
  - A write to an entry that has not yet been read this run is picked up by this run.
- FSM states: IDLE, FETCH, LOAD, GAP, SETTLE, SET, DONE.
  - IDLE: start=1 → latch sel_out/sel_in, go to FETCH, busy=1 from the next cycle.
    - If both selects are 0, go directly to SETTLE.
  - FETCH: issue synchronous table read for the current address → LOAD.
  - LOAD: ld_delay=1, with dly_addr and dly_data valid in the same cycle.
    - Last address → SETTLE.
    - Otherwise → GAP if LD_GAP>0, else FETCH.
    - ld_delay period is therefore LD_GAP+2 cycles.
  - GAP: count LD_GAP cycles → FETCH.
  - SETTLE: count SETTLE_CYCLES cycles → SET.
  - SET: set=1 for exactly one cycle → DONE.
  - DONE: done=1, busy=0 in this same cycle → IDLE.
- Latency: start sampled at cycle T → first ld_delay at T+2.
  - Full run with LD_GAP=0 and SETTLE_CYCLES=2: 19 loads at T+2, T+4, …, T+38; set at T+41; done at T+42.
- start while busy or in DONE: ignored, with no queuing.
- dly_addr and dly_data hold their last values when ld_delay=0.
- rst asserted mid-sequence: the next cycle shows reset output values and the FSM is in IDLE. No set is issued. The table is unchanged.

Optional Feature:
Macro: BYTE_LANE_DLY_DIRTY_EN.
- With the macro defined:
  - A dirty bit per implemented address is set on wr_en to that address.
  - The dirty bit is cleared when its entry is loaded; a write in the same cycle as the load keeps it set.
  - Non-dirty addresses are skipped with no FETCH/LOAD cycles.
  - Dirty bits reset to all-ones, so the first run after reset is full.
  - set is still issued even if zero addresses were loaded.
- Without the macro: every selected address is loaded on every run.

Decomposition:
- Package byte_lane_dly_pkg holds:
  - address constants (DQ_BASE=0, DQS_OUT=8, DM_OUT=9, IN_BASE=16, DQS_IN=24);
  - per-group counts (10, 9);
  - the FSM state enum.
- One sub-module, byte_lane_dly_addr_seq:
  - given the current address, group selects and (optional) dirty mask, produces the next address and a last flag;
  - purely combinational, with a registered pointer kept in the parent.

Test Plan:
- Table 0..9 = 8'h10+i and 16..24 = 8'h40+i; start with sel_out=sel_in=1, LD_GAP=0 → 19 ld_delay strobes with addr/data pairs (0,10h)…(9,19h),(16,40h)…(24,48h), set at T+41, done at T+42, busy high T+1..T+41.
- sel_out=1, sel_in=0, LD_GAP=3 → 10 strobes spaced 5 cycles apart, addresses 0-9 only, then one set.
- sel_out=0, sel_in=0 → no ld_delay; set at T+1+SETTLE_CYCLES; done on the next cycle.
- Second start pulse 5 cycles into a run, plus rst pulse at the 6th ld_delay → no extra sequence, outputs zero the next cycle, no set, subsequent start runs a full sequence.
- Mid-run, write addr 20 = 8'hAB before it is fetched, and addr 3 = 8'hCD after it is loaded → addr 20 emitted as ABh; addr 3 keeps its old value this run and is emitted as CDh on the next run.
- BYTE_LANE_DLY_DIRTY_EN: after a full run, write only addrs 5 and 22, then start → exactly 2 strobes (5, 22), then set.
